// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter with bounded lock, sharing one synchronous memory port.
// Latency: grant is combinational in the request cycle; read data/rvalid follow one cycle later.
// Backpressure: a requester that is not granted stalls and holds its request until gntN.
//
// Ports:
//   clk, reset               clock and synchronous active-high reset
//   reqN/lockN/weN           requester N access request, ownership hold, write select
//   addrN/wdataN             requester N address and write data
//   gntN                     access issued to memory this cycle for requester N
//   rvalidN/rdataN           read return for requester N, one cycle after its read grant
//   memAddr/memStrobe/memWe/memDataWrite/memDataRead   shared memory port
module mem_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_LOCK   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  lock0,
  input  logic                  lock1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic                  memStrobe,
  output logic                  memWe,
  output logic [DATA_WIDTH-1:0] memDataWrite,
  input  logic [DATA_WIDTH-1:0] memDataRead
);

  localparam int CW = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(MAX_LOCK);
  // A one-cycle span is just a normal grant, so ownership is never taken.
  localparam bit LOCK_EN = (MAX_LOCK > 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } acc_t;

  state_t          state;
  logic            rrLast;     // index of the most recently granted port
  logic [CW-1:0]   lockCnt;    // cycles spent in the current ownership span
  logic            rvalid0Q;
  logic            rvalid1Q;
  logic            ownLock;
  acc_t            acc0;
  acc_t            acc1;
  acc_t            accSel;

  // Grant decision. rrLast==1 means port 0 wins a tie.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (req0 && (!req1 || rrLast)) gnt0 = 1'b1;
          else if (req1)                 gnt1 = 1'b1;
        end
        OWN0:    gnt0 = req0;
        OWN1:    gnt1 = req1;
        default: ;
      endcase
    end
  end

  assign ownLock = (state == OWN1) ? lock1 : lock0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rrLast   <= 1'b1;
      lockCnt  <= '0;
      rvalid0Q <= 1'b0;
      rvalid1Q <= 1'b0;
    end else begin
      rvalid0Q <= gnt0 & ~we0;
      rvalid1Q <= gnt1 & ~we1;

      if (gnt0)      rrLast <= 1'b0;
      else if (gnt1) rrLast <= 1'b1;

      case (state)
        IDLE: begin
          if (LOCK_EN && gnt0 && lock0) begin
            state   <= OWN0;
            lockCnt <= CW'(1);
          end else if (LOCK_EN && gnt1 && lock1) begin
            state   <= OWN1;
            lockCnt <= CW'(1);
          end
        end
        OWN0, OWN1: begin
          // Release on lock drop, or forcibly when the span reaches MAX_LOCK.
          // rrLast already points at the owner, so the other port wins the next tie.
          if (!ownLock || (lockCnt + CW'(1)) == LOCK_LAST) begin
            state   <= IDLE;
            lockCnt <= '0;
          end else begin
            lockCnt <= lockCnt + CW'(1);
          end
        end
        default: begin
          state   <= IDLE;
          lockCnt <= '0;
        end
      endcase
    end
  end

  assign acc0   = '{we: we0, addr: addr0, wdata: wdata0};
  assign acc1   = '{we: we1, addr: addr1, wdata: wdata1};
  assign accSel = gnt1 ? acc1 : (gnt0 ? acc0 : '0);

  assign memAddr      = accSel.addr;
  assign memWe        = accSel.we;
  assign memDataWrite = accSel.wdata;
  assign memStrobe    = gnt0 | gnt1;

  // A read return landing while reset is held is discarded.
  assign rvalid0 = rvalid0Q & ~reset;
  assign rvalid1 = rvalid1Q & ~reset;
  assign rdata0  = memDataRead;
  assign rdata1  = memDataRead;

endmodule
